// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the digit-serial multiplier.
//   SEQ_MUL_N_DEFAULT : default operand width
//   state_t           : control FSM encoding (IDLE, RUN, HOLD)
//   idx_width()       : bit width of a digit index for an N-bit operand
package seq_mul_pkg;

  localparam int unsigned SEQ_MUL_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // clog2 of the digit count, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned d;
    d = n / 2;
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/digit_mul_2x2.sv
// Combinational 2-bit x 2-bit unsigned multiplier.
//   x, y : 2-bit digits
//   p    : 4-bit product (max 9)
module digit_mul_2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);

  logic pp00, pp01, pp10, pp11;
  logic c1;

  // partial products
  assign pp00 = x[0] & y[0];
  assign pp01 = x[1] & y[0];
  assign pp10 = x[0] & y[1];
  assign pp11 = x[1] & y[1];

  // half-adder on the weight-2 column, then half-adder into weight 4
  assign p[0] = pp00;
  assign p[1] = pp01 ^ pp10;
  assign c1   = pp01 & pp10;
  assign p[2] = pp11 ^ c1;
  assign p[3] = pp11 & c1;

endmodule

// File: rtl/seq_mul_digit.sv
// Sequential N x N unsigned multiplier, one 2x2 digit product per clock.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid, in_ready : operand handshake (a, b accepted in IDLE)
//   a, b               : N-bit unsigned operands
//   out_valid,out_ready: result handshake (held in HOLD)
//   out                : 2N-bit product, stable until the next completion
module seq_mul_digit
  import seq_mul_pkg::*;
#(
  parameter int unsigned N = SEQ_MUL_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out
);

  localparam int unsigned D  = N / 2;
  localparam int unsigned IW = idx_width(N);
  localparam int unsigned AW = 2 * N;

  state_t          state;
  logic [N-1:0]    a_q, b_q;
  logic [AW-1:0]   acc;
  logic [IW-1:0]   i, j;

  logic [1:0]      a_dig, b_dig;
  logic [3:0]      p;
  logic [IW:0]     ij;
  logic [AW-1:0]   acc_nxt;
  logic            j_last, i_last;

  // current digit pair; i walks a, j walks b
  assign a_dig = a_q[{i, 1'b0} +: 2];
  assign b_dig = b_q[{j, 1'b0} +: 2];

  digit_mul_2x2 u_dmul (
    .x (a_dig),
    .y (b_dig),
    .p (p)
  );

  // weight of the digit product is 4^(i+j)
  always_comb begin
    ij      = (IW + 1)'(i) + (IW + 1)'(j);
    acc_nxt = acc + (AW'(p) << {ij, 1'b0});
    j_last  = (j == IW'(D - 1));
    i_last  = (i == IW'(D - 1));
  end

  // control FSM, counters and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      i         <= '0;
      j         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          if (j_last) begin
            j <= '0;
            i <= i_last ? '0 : i + IW'(1);
          end else begin
            j <= j + IW'(1);
          end
          // final digit pair: publish the completed sum
          if (i_last && j_last) begin
            out       <= acc_nxt;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_digit.sv
// Self-checking bench for seq_mul_digit (N=8): directed cases plus a random
// handshake stream checked against plain a*b arithmetic.
module tb_seq_mul_digit;

  localparam int unsigned N = 8;
  localparam int unsigned K = (N / 2) * (N / 2);

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out;

  int total = 0;
  int bad   = 0;

  seq_mul_digit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // tick until out_valid, return number of edges taken (bounded)
  task automatic wait_done(input logic [2*N-1:0] prev, output int lat, output logic leak);
    lat  = 0;
    leak = 1'b0;
    while (out_valid !== 1'b1 && lat < 4 * K) begin
      if (out !== prev || in_ready !== 1'b0) leak = 1'b1;
      tick();
      lat++;
    end
  endtask

  // full transaction with out_ready high; returns nothing, checks everything
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [2*N-1:0] expv;
    logic [2*N-1:0] prev;
    int             lat;
    logic           leak;
    expv      = (2*N)'(av) * (2*N)'(bv);
    prev      = out;
    out_ready = 1'b1;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    a         = N'($urandom);
    b         = N'($urandom);
    wait_done(prev, lat, leak);
    chk({tag, "_latency"}, 32'(lat), 32'(K));
    chk({tag, "_no_partial"}, 32'(leak), 32'd0);
    chk({tag, "_out"}, 32'(out), 32'(expv));
    tick();
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_kept"}, 32'(out), 32'(expv));
  endtask

  logic [N-1:0]   ca [4];
  logic [N-1:0]   cb [4];
  logic [2*N-1:0] q [$];
  logic [2*N-1:0] expv;
  logic           changed;
  logic           overlap;
  logic           acc_now;
  logic           done_now;
  int             sent;
  int             got;
  int             cyc;
  int             lat;
  logic           leak;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // reset asserted mid-idle takes effect without a clock edge
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    tick();
    rst = 1'b0;

    // idle with no input activity stays put
    changed = 1'b0;
    for (int k = 0; k < 20; k++) begin
      a = N'($urandom);
      b = N'($urandom);
      tick();
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0) changed = 1'b1;
    end
    chk("idle_stable", 32'(changed), 32'd0);

    // basic product
    run_op("basic_13x11", 8'd13, 8'd11);
    chk("basic_value", 32'(out), 32'h008F);

    // corner operands
    ca[0] = 8'd255; cb[0] = 8'd255;
    ca[1] = 8'd0;   cb[1] = 8'd200;
    ca[2] = 8'd1;   cb[2] = 8'd255;
    ca[3] = 8'd170; cb[3] = 8'd85;
    for (int k = 0; k < 4; k++) run_op($sformatf("corner%0d", k), ca[k], cb[k]);

    // back-pressure: result held while out_ready is low
    out_ready = 1'b0;
    a         = 8'd200;
    b         = 8'd3;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_done(out, lat, leak);
    chk("bp_latency", 32'(lat), 32'(K));
    changed = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a        = N'($urandom);
      b        = N'($urandom);
      in_valid = 1'($urandom);
      tick();
      if (out !== 16'd600 || out_valid !== 1'b1 || in_ready !== 1'b0) changed = 1'b1;
    end
    chk("bp_hold_stable", 32'(changed), 32'd0);
    chk("bp_out", 32'(out), 32'd600);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // reset in the middle of a run discards the partial result
    a        = 8'd255;
    b        = 8'd255;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out", 32'(out), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("after_abort", 8'd2, 8'd3);

    // random stream, in_valid held, random back-pressure
    sent     = 0;
    got      = 0;
    cyc      = 0;
    overlap  = 1'b0;
    a        = N'($urandom);
    b        = N'($urandom);
    in_valid = 1'b1;
    while (got < 50 && cyc < 5000) begin
      out_ready = 1'($urandom);
      if (in_ready === 1'b1 && out_valid === 1'b1) overlap = 1'b1;
      acc_now  = (in_ready === 1'b1) && in_valid;
      done_now = (out_valid === 1'b1) && out_ready;
      if (done_now) begin
        if (q.size() == 0) expv = 'x;
        else expv = q.pop_front();
        chk($sformatf("stream%0d", got), 32'(out), 32'(expv));
        got++;
      end
      if (acc_now) q.push_back((2*N)'(a) * (2*N)'(b));
      tick();
      if (acc_now) begin
        sent++;
        a = N'($urandom);
        b = N'($urandom);
        if (sent == 50) in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'd50);
    chk("stream_got", 32'(got), 32'd50);
    chk("stream_queue_empty", 32'(q.size()), 32'd0);
    chk("stream_ready_valid_exclusive", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
